link_ddr_rx_sipo: RTL and testbench
===================================

# link_ddr_rx_sipo

Receive-side deserializer that sits directly downstream of the DDR upstream link output stage. It takes the per-channel SDR beats that the upstream PISO drives onto `io_data_r_o`/`io_valid_r_o`, with beat 0 carrying the low bits. It reassembles them into core-width words, buffers those words in a small FIFO toward the core, and returns flow-control credits as a toggling token that the upstream token counter consumes.

## Interface
- `channel_width_p`, 8: bits per channel per beat.
- `num_channels_p`, 2: parallel channels; beat width `B = channel_width_p*num_channels_p`.
- `core_width_p`, 64: reassembled word width; must be an integer multiple of B; `beats = core_width_p/B` (default 4).
- `lg_fifo_depth_p`, 3: FIFO holds 2^lg_fifo_depth_p words.
- `lg_credit_decimation_p`, 1: `token_o` toggles once every 2^lg_credit_decimation_p consumed words.
- `io_clk_i` in 1: sole clock; all state is on the rising edge.
- `io_link_reset_i` in 1: reset, asynchronous and active-high.
- `io_valid_i` in num_channels_p: per-channel beat valid.
- `io_data_i` in B: channel c occupies bits `[c*channel_width_p +: channel_width_p]`.
- `core_valid_o` out 1: FIFO head valid.
- `core_data_o` out core_width_p: FIFO head word.
- `core_yumi_i` in 1: core consumes the head this cycle; legal only when `core_valid_o` is high.
- `token_o` out 1: credit token; every toggle equals one credit batch.
- `error_o` out 1: sticky protocol-error flag.

## Operation
- Reset (asynchronous assert): beat counter 0, shift register cleared, FIFO empty, `core_valid_o` 0, `core_data_o` 0, credit counter 0, `token_o` 0, `error_o` 0. A partially assembled word is discarded.
- Beat acceptance:
  - All bits of `io_valid_i` high: the beat is accepted.
  - All bits low: idle.
  - Any other pattern: a mismatch. The beat is discarded, `error_o` is set, and the beat counter is unchanged.
- Assembly: an accepted beat at count k writes `io_data_i` into word bits `[k*B +: B]`. The counter increments and wraps from beats-1 to 0. On the last beat (k = beats-1) the completed word, including the current beat, is pushed to the FIFO.
- FIFO:
  - Push while full with no same-cycle pop: overflow. The word is dropped, `error_o` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and there is no error.
  - Push and pop in the same cycle while empty: not possible, because there is no bypass.
- `core_yumi_i` while empty: ignored, FIFO unchanged, `error_o` set.
- Credits: each accepted `core_yumi_i` increments a lg_credit_decimation_p-bit counter. When the counter wraps to 0, `token_o` inverts on the same edge.
- `error_o` clears only on reset.

## Timing
- Latency: the last beat sampled at edge t produces `core_valid_o` = 1 and `core_data_o` = word after edge t, i.e. visible in cycle t+1.
- Sustained throughput: one word per `beats` cycles in, one word per cycle out.
- Pop: `core_yumi_i` sampled at edge t presents the next entry, or `core_valid_o` = 0, in cycle t+1.
- Token: the toggle is registered and changes at the edge that samples the decimation-completing yumi.
- Outputs are registered or derived only from registered state; there is no combinational path from `io_*` inputs to `core_*` outputs.
- FIFO pointers are lg_fifo_depth_p+1 bits wide. Full is detected by equal low bits and differing MSB. Wrap-around is exercised at depth 2^lg_fifo_depth_p.

## Structure
- Package `link_ddr_rx_pkg`:
  - localparam function `beats(core_width, channel_width, num_channels)`.
  - Default width constants.
  - Error-cause enum {ERR_NONE, ERR_VALID_MISMATCH, ERR_OVERFLOW, ERR_UNDERFLOW}, exposed for debug only; the internal cause register is last-cause-wins.
- Sub-module `link_ddr_rx_fifo`:
  - Parameterised width and lg depth.
  - Ports: valid/data in, ready out, valid/data out, yumi in, and the same clock/reset.
- The top level holds the beat counter, shift register, credit counter and error logic.

## Test plan
- **Single word:** after reset, drive `io_valid_i`=2'b11 for 4 cycles with data 16'h1100, 16'h3322, 16'h5544, 16'h7766.
  - `core_data_o` = 64'h7766_5544_3322_1100 and `core_valid_o` = 1 one cycle after the last beat.
- **Backpressure/overflow:** push 8 words with yumi held low; the FIFO is full and `error_o` stays 0. A 9th word sets `error_o` = 1.
  - Draining then yields exactly the first 8 words in order.
- **Full push+pop:** with the FIFO full, pulse `core_yumi_i` in the same cycle as a last beat. `error_o` stays 0 and the FIFO remains full with the new word at the tail.
- **Credits:** consume 6 words with lg_credit_decimation_p=1. `token_o` toggles 3 times, following 0→1→0→1 after the 2nd, 4th and 6th yumi.
- **Valid mismatch:** drive 2 good beats, then `io_valid_i`=2'b01, then 2 good beats. `error_o` = 1, and the emitted word is composed of the 4 good beats only.
- **Reset mid-word:** assert `io_link_reset_i` asynchronously after beat 2. All outputs reset immediately.
  - After release, a fresh 4-beat word is emitted correctly with no residue from before reset.

Source files
------------

// File: rtl/link_ddr_rx_pkg.sv
// link_ddr_rx_pkg: shared constants, types and helpers for the DDR link receive
// deserializer (link_ddr_rx_sipo) and its word FIFO (link_ddr_rx_fifo).
//   - default width constants for the link/core geometry
//   - beats(): number of link beats that make up one core word
//   - err_cause_e: debug encoding of the most recent protocol error
package link_ddr_rx_pkg;

  localparam int CHANNEL_WIDTH_DEF  = 8;
  localparam int NUM_CHANNELS_DEF   = 2;
  localparam int CORE_WIDTH_DEF     = 64;
  localparam int LG_FIFO_DEPTH_DEF  = 3;
  localparam int LG_CREDIT_DEC_DEF  = 1;

  // Number of beats of width channel_width*num_channels per core word.
  function automatic int beats(input int core_width, input int channel_width,
                               input int num_channels);
    return core_width / (channel_width * num_channels);
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_VALID_MISMATCH = 2'd1,
    ERR_OVERFLOW       = 2'd2,
    ERR_UNDERFLOW      = 2'd3
  } err_cause_e;

endpackage

// File: rtl/link_ddr_rx_fifo.sv
// link_ddr_rx_fifo: 2^lg_depth_p entry word FIFO with registered storage and
// valid/yumi handshake on the output.
// Ports:
//   io_clk_i, io_link_reset_i : clock, async active-high reset
//   v_i, data_i, ready_o      : push side (push happens when v_i & ready_o)
//   v_o, data_o, yumi_i       : pop side (head word; yumi_i consumes it)
// A push into a full FIFO succeeds only if a pop happens on the same edge.
// There is no bypass: a word pushed into an empty FIFO appears one cycle later.
module link_ddr_rx_fifo
  import link_ddr_rx_pkg::*;
#(
  parameter int width_p    = CORE_WIDTH_DEF,
  parameter int lg_depth_p = LG_FIFO_DEPTH_DEF
) (
  input  logic               io_clk_i,
  input  logic               io_link_reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int DEPTH = 1 << lg_depth_p;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [lg_depth_p:0] r_wptr;
  logic [lg_depth_p:0] r_rptr;
  logic [width_p-1:0]  r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_wptr[lg_depth_p] != r_rptr[lg_depth_p]) &&
                   (r_wptr[lg_depth_p-1:0] == r_rptr[lg_depth_p-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = yumi_i & ~w_empty;
  assign w_push  = v_i & (~w_full | w_pop);

  assign ready_o = ~w_full | w_pop;
  assign v_o     = ~w_empty;
  assign data_o  = r_mem[r_rptr[lg_depth_p-1:0]];

  // Pointer update; ignored pops (empty) and dropped pushes (full) leave state alone.
  always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
    if (io_link_reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (lg_depth_p + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (lg_depth_p + 1)'(1);
    end
  end

  // Storage write; cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
    if (io_link_reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr[lg_depth_p-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/link_ddr_rx_sipo.sv
// link_ddr_rx_sipo: receive-side deserializer for the DDR link. Collects
// per-channel SDR beats (beat 0 = low bits) into core-width words, queues them
// in link_ddr_rx_fifo toward the core and returns credits as a toggling token.
// Ports:
//   io_clk_i, io_link_reset_i : clock, async active-high reset
//   io_valid_i, io_data_i     : per-channel beat valid and beat data
//   core_valid_o, core_data_o : FIFO head toward the core
//   core_yumi_i               : core consumes the head this cycle
//   token_o                   : toggles once per 2^lg_credit_decimation_p pops
//   error_o                   : sticky protocol error (mismatch/overflow/underflow)
module link_ddr_rx_sipo
  import link_ddr_rx_pkg::*;
#(
  parameter int channel_width_p        = CHANNEL_WIDTH_DEF,
  parameter int num_channels_p         = NUM_CHANNELS_DEF,
  parameter int core_width_p           = CORE_WIDTH_DEF,
  parameter int lg_fifo_depth_p        = LG_FIFO_DEPTH_DEF,
  parameter int lg_credit_decimation_p = LG_CREDIT_DEC_DEF
) (
  input  logic                                      io_clk_i,
  input  logic                                      io_link_reset_i,
  input  logic [num_channels_p-1:0]                 io_valid_i,
  input  logic [channel_width_p*num_channels_p-1:0] io_data_i,
  output logic                                      core_valid_o,
  output logic [core_width_p-1:0]                   core_data_o,
  input  logic                                      core_yumi_i,
  output logic                                      token_o,
  output logic                                      error_o
);

  localparam int B     = channel_width_p * num_channels_p;
  localparam int BEATS = beats(core_width_p, channel_width_p, num_channels_p);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]                  r_beat_cnt;
  logic [core_width_p-1:0]           r_word;
  logic [lg_credit_decimation_p-1:0] r_credit_cnt;
  logic                              r_token;
  err_cause_e                        r_err_cause;

  logic                    w_all_valid;
  logic                    w_mismatch;
  logic                    w_last;
  logic                    w_push;
  logic                    w_fifo_ready;
  logic                    w_overflow;
  logic                    w_underflow;
  logic                    w_pop;
  logic [core_width_p-1:0] w_word;

  assign w_all_valid = &io_valid_i;
  assign w_mismatch  = (|io_valid_i) & ~w_all_valid;
  assign w_last      = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_push      = w_all_valid & w_last;
  assign w_overflow  = w_push & ~w_fifo_ready;
  assign w_underflow = core_yumi_i & ~core_valid_o;
  assign w_pop       = core_yumi_i & core_valid_o;

  // Word being assembled with the current beat merged into its slot, so the
  // last beat can be pushed on the same edge it is sampled.
  always_comb begin
    w_word = r_word;
    w_word[r_beat_cnt*B +: B] = io_data_i;
  end

  // Beat counter and shift register; mismatched and idle beats leave both alone.
  always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
    if (io_link_reset_i) begin
      r_beat_cnt <= '0;
      r_word     <= '0;
    end else if (w_all_valid) begin
      r_word     <= w_word;
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  link_ddr_rx_fifo #(
    .width_p    (core_width_p),
    .lg_depth_p (lg_fifo_depth_p)
  ) u_fifo (
    .io_clk_i        (io_clk_i),
    .io_link_reset_i (io_link_reset_i),
    .v_i             (w_push),
    .data_i          (w_word),
    .ready_o         (w_fifo_ready),
    .v_o             (core_valid_o),
    .data_o          (core_data_o),
    .yumi_i          (core_yumi_i)
  );

  // Credit counter; the token flips on the edge where the counter wraps to 0.
  always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
    if (io_link_reset_i) begin
      r_credit_cnt <= '0;
      r_token      <= 1'b0;
    end else if (w_pop) begin
      r_credit_cnt <= r_credit_cnt + lg_credit_decimation_p'(1);
      if (r_credit_cnt == '1) r_token <= ~r_token;
    end
  end

  // Last error cause; never returns to ERR_NONE, so it doubles as the sticky flag.
  always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
    if (io_link_reset_i) begin
      r_err_cause <= ERR_NONE;
    end else if (w_underflow) begin
      r_err_cause <= ERR_UNDERFLOW;
    end else if (w_overflow) begin
      r_err_cause <= ERR_OVERFLOW;
    end else if (w_mismatch) begin
      r_err_cause <= ERR_VALID_MISMATCH;
    end
  end

  assign token_o = r_token;
  assign error_o = (r_err_cause != ERR_NONE);

endmodule

// File: tb/tb_link_ddr_rx_sipo.sv
module tb_link_ddr_rx_sipo;

  localparam int CW    = 8;
  localparam int NC    = 2;
  localparam int B     = CW * NC;
  localparam int CORE  = 64;
  localparam int BEATS = CORE / B;
  localparam int LGD   = 3;
  localparam int DEPTH = 1 << LGD;
  localparam int LGC   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   io_valid;
  logic [B-1:0]    io_data;
  logic            core_valid;
  logic [CORE-1:0] core_data;
  logic            core_yumi;
  logic            token;
  logic            error;

  always #5 clk = ~clk;

  link_ddr_rx_sipo #(
    .channel_width_p        (CW),
    .num_channels_p         (NC),
    .core_width_p           (CORE),
    .lg_fifo_depth_p        (LGD),
    .lg_credit_decimation_p (LGC)
  ) dut (
    .io_clk_i        (clk),
    .io_link_reset_i (rst),
    .io_valid_i      (io_valid),
    .io_data_i       (io_data),
    .core_valid_o    (core_valid),
    .core_data_o     (core_data),
    .core_yumi_i     (core_yumi),
    .token_o         (token),
    .error_o         (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words are lists of beats, the FIFO is a queue of words.
  logic [CORE-1:0] sb_q[$];
  logic [B-1:0]    m_beats[$];
  int              m_occ;
  bit              m_err;
  int              m_yumis;

  function automatic bit m_token();
    return ((m_yumis >> LGC) % 2) != 0;
  endfunction

  task automatic check(input string name, input logic [CORE-1:0] act, input logic [CORE-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_beats.delete();
    m_occ   = 0;
    m_err   = 1'b0;
    m_yumis = 0;
  endtask

  // What the link should do with one clock edge of inputs.
  task automatic model_step(input logic [NC-1:0] v, input logic [B-1:0] d, input logic y);
    logic [CORE-1:0] w;
    bit pop;
    pop = y && (m_occ > 0);
    if (y && m_occ == 0) m_err = 1'b1;
    if (pop) m_yumis++;
    if (v == '1) begin
      m_beats.push_back(d);
      if (m_beats.size() == BEATS) begin
        w = '0;
        for (int i = 0; i < BEATS; i++) w[i*B +: B] = m_beats[i];
        m_beats.delete();
        if (m_occ < DEPTH || pop) begin
          sb_q.push_back(w);
          m_occ++;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (v != '0) begin
      m_err = 1'b1;
    end
    if (pop) m_occ--;
  endtask

  task automatic cycle(input logic [NC-1:0] v, input logic [B-1:0] d, input logic y);
    io_valid  = v;
    io_data   = d;
    core_yumi = y;
    @(posedge clk);
    model_step(v, d, y);
    #1;
  endtask

  task automatic push_word(input logic [CORE-1:0] w, input logic y_last);
    for (int i = 0; i < BEATS; i++) cycle('1, w[i*B +: B], (i == BEATS - 1) ? y_last : 1'b0);
  endtask

  task automatic pop_one();
    cycle('0, '0, 1'b1);
  endtask

  task automatic do_reset();
    io_valid  = '0;
    io_data   = '0;
    core_yumi = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_valid", 64'(core_valid), 64'(0));
    check("rst_data", core_data, 64'(0));
    check("rst_token", 64'(token), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT's head, flags and token each cycle; retires
  // expected words whenever the core consumes one.
  initial begin
    forever begin
      @(negedge clk);
      check("core_valid", 64'(core_valid), 64'(m_occ > 0));
      check("error", 64'(error), 64'(m_err));
      check("token", 64'(token), 64'(m_token()));
      if (sb_q.size() != 0) begin
        check("core_data", core_data, sb_q[0]);
        if (core_yumi) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [CORE-1:0] w;
    logic [B-1:0]    d0, d1, d2, d3;
    bit              exp_tok [6];
    int              r;

    rst       = 1'b1;
    io_valid  = '0;
    io_data   = '0;
    core_yumi = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("init_valid", 64'(core_valid), 64'(0));
    check("init_data", core_data, 64'(0));

    // Single word.
    cycle(2'b11, 16'h1100, 1'b0);
    cycle(2'b11, 16'h3322, 1'b0);
    cycle(2'b11, 16'h5544, 1'b0);
    check("pre_last_valid", 64'(core_valid), 64'(0));
    cycle(2'b11, 16'h7766, 1'b0);
    check("single_valid", 64'(core_valid), 64'(1));
    check("single_data", core_data, 64'h7766_5544_3322_1100);
    pop_one();

    // Backpressure / overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word({32'($urandom), 32'($urandom)}, 1'b0);
    check("full_no_error", 64'(error), 64'(0));
    push_word(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    check("overflow_error", 64'(error), 64'(1));
    for (int i = 0; i < DEPTH; i++) pop_one();
    check("drained_valid", 64'(core_valid), 64'(0));

    // Full push+pop on the same edge.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word({32'($urandom), 32'($urandom)}, 1'b0);
    push_word(64'h0123_4567_89AB_CDEF, 1'b1);
    check("pushpop_error", 64'(error), 64'(0));
    for (int i = 0; i < DEPTH - 1; i++) pop_one();
    check("tail_word", core_data, 64'h0123_4567_89AB_CDEF);
    pop_one();
    check("pushpop_empty", 64'(core_valid), 64'(0));

    // Credits.
    do_reset();
    for (int i = 0; i < 6; i++) push_word({32'($urandom), 32'($urandom)}, 1'b0);
    exp_tok = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      pop_one();
      check($sformatf("token_after_yumi%0d", i + 1), 64'(token), 64'(exp_tok[i]));
    end

    // Valid mismatch.
    do_reset();
    d0 = 16'hA1B2; d1 = 16'hC3D4; d2 = 16'hE5F6; d3 = 16'h0718;
    cycle(2'b11, d0, 1'b0);
    cycle(2'b11, d1, 1'b0);
    cycle(2'b01, 16'hFFFF, 1'b0);
    check("mismatch_error", 64'(error), 64'(1));
    cycle(2'b11, d2, 1'b0);
    cycle(2'b11, d3, 1'b0);
    check("mismatch_word", core_data, {d3, d2, d1, d0});
    pop_one();

    // Reset mid-word.
    do_reset();
    push_word(64'h1111_2222_3333_4444, 1'b0);
    cycle(2'b11, 16'hAAAA, 1'b0);
    cycle(2'b11, 16'hBBBB, 1'b0);
    do_reset();
    push_word(64'h5555_6666_7777_8888, 1'b0);
    check("post_reset_word", core_data, 64'h5555_6666_7777_8888);
    pop_one();

    // Randomized traffic at several pop rates.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 300; c++) begin
        r = int'($urandom_range(0, 9));
        w = {32'($urandom), 32'($urandom)};
        cycle((r < 7) ? 2'b11 : 2'b00, w[B-1:0],
              (m_occ > 0) && ($urandom_range(0, 7) < 2 * ph));
      end
    end
    while (m_occ > 0) pop_one();

    // Underflow.
    cycle('0, '0, 1'b1);
    check("underflow_error", 64'(error), 64'(1));
    cycle('0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
